hilo_ctrl: RTL

Sequencer and architectural HI/LO register file that sits downstream of the divider and the multiplier.
- Turns one-cycle op requests from the main control unit into `start` pulses for the divider or multiplier.
- Times the fixed latency of the selected unit, then captures its hi/lo results into the HI and LO registers.
- Services mthi/mtlo writes.
- Raises `busy` so control stalls the CPU, and pulses a divide-by-zero exception.

---
 rtl/hilo_ctrl_pkg.sv | 16 +
 rtl/hilo_latency_cnt.sv | 30 +++
 rtl/hilo_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer: state encoding and the unit
// latencies that the divider, multiplier and hilo_ctrl must agree on.
package hilo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        MULT_RUN = 2'd2,
        CAPTURE  = 2'd3
    } hilo_state_t;

    localparam int HILO_DIV_LATENCY  = 32;
    localparam int HILO_MULT_LATENCY = 33;
    localparam int HILO_CNT_W        = 6;

endpackage

// File: rtl/hilo_latency_cnt.sv
// Load/decrement latency counter; tc flags the last running cycle (count == 1).
module hilo_latency_cnt
    import hilo_ctrl_pkg::*;
#(
    parameter int CNT_W = HILO_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Decrement saturates at zero so the counter can never wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: issues divider/multiplier starts, waits out the fixed
// latency, captures results into HI/LO and services mthi/mtlo writes.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DIV_LATENCY  = HILO_DIV_LATENCY,
    parameter int MULT_LATENCY = HILO_MULT_LATENCY,
    parameter int CNT_W        = HILO_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_div,
    input  logic              op_mult,
    input  logic              op_mthi,
    input  logic              op_mtlo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] div_hi,
    input  logic [DATA_W-1:0] div_lo,
    input  logic              div_divzero,
    input  logic [DATA_W-1:0] mult_hi,
    input  logic [DATA_W-1:0] mult_lo,
    output logic              div_start,
    output logic              mult_start,
    output logic              busy,
    output logic              done,
    output logic              divzero_exc,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY);

    hilo_state_t state;
    logic        src_div;
    logic        tc;
    logic        accept;
    logic        issue_div;
    logic        issue_mult;
    logic        wr_ok;
    logic        running;

    // busy also covers the done cycle, so new requests are only taken once
    // the captured HI/LO values have been visible for a full cycle.
    assign accept     = (state == IDLE) && !busy;
    assign issue_div  = accept && op_div;
    assign issue_mult = accept && op_mult && !op_div;
    assign wr_ok      = accept && !op_div && !op_mult;
    assign running    = (state == DIV_RUN) || (state == MULT_RUN);

    hilo_latency_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (issue_div || issue_mult),
        .load_val (issue_div ? DIV_LOAD : MULT_LOAD),
        .dec      (running),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            src_div     <= 1'b0;
            busy        <= 1'b0;
            div_start   <= 1'b0;
            mult_start  <= 1'b0;
            done        <= 1'b0;
            divzero_exc <= 1'b0;
        end else begin
            div_start   <= issue_div;
            mult_start  <= issue_mult;
            done        <= 1'b0;
            divzero_exc <= 1'b0;

            if (issue_div || issue_mult) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (issue_div) begin
                        state   <= DIV_RUN;
                        src_div <= 1'b1;
                    end else if (issue_mult) begin
                        state   <= MULT_RUN;
                        src_div <= 1'b0;
                    end
                end
                DIV_RUN, MULT_RUN: begin
                    if (tc) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state       <= IDLE;
                    done        <= 1'b1;
                    divzero_exc <= src_div && div_divzero;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A zero-divisor divide leaves HI/LO untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == CAPTURE) begin
            if (!src_div) begin
                hi <= mult_hi;
                lo <= mult_lo;
            end else if (!div_divzero) begin
                hi <= div_hi;
                lo <= div_lo;
            end
        end else if (wr_ok) begin
            if (op_mthi) hi <= wdata;
            if (op_mtlo) lo <= wdata;
        end
    end

endmodule
